// File: rtl/background_renderer.sv
// -----------------------------------------------------------------------------
// background_renderer
//
// Purpose:
//   Maps each visible screen pixel onto a 128x128 one-bit background image,
//   magnified by 2^SCALE_SHIFT on each axis. The image can scroll horizontally,
//   with wrap-around. The horizontal offset (scroll_x) moves only once per
//   frame, on the cycle after a qualified frame_start pulse. Each pixel goes
//   through a fixed three-stage pipeline:
//     S1  registers the ROM address (and the pixel-valid flag)
//     S2  waits for the synchronous ROM read
//     S3  registers the final colour and bg_on
//
// Ports:
//   Clk          rising-edge clock for all logic
//   Reset_n      synchronous, active-low reset
//   DrawX/DrawY  current pixel column/row (0-639 / 0-479)
//   pixel_valid  DrawX/DrawY lie in the visible area
//   frame_start  single-cycle pulse during vertical blanking
//   scroll_en    allows a scroll update at frame_start
//   scroll_dir   0 = offset increments (scroll left), 1 = offset decrements
//   scroll_step  number of texels moved per update
//   rom_data     texel bit, valid one cycle after rom_addr
//   rom_addr     registered ROM address {1'b0, v[6:0], u[6:0]}
//   bg_on        bg_Red/Green/Blue hold a valid background pixel
//   bg_Red/Green/Blue  background colour
// -----------------------------------------------------------------------------
module background_renderer #(
    parameter int          SCALE_SHIFT = 2,
    parameter logic [23:0] COLOR1      = 24'h7F3F1F,
    parameter logic [23:0] COLOR0      = 24'h000000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        pixel_valid,
    input  logic        frame_start,
    input  logic        scroll_en,
    input  logic        scroll_dir,
    input  logic [3:0]  scroll_step,
    input  logic        rom_data,
    output logic [14:0] rom_addr,
    output logic        bg_on,
    output logic [7:0]  bg_Red,
    output logic [7:0]  bg_Green,
    output logic [7:0]  bg_Blue
);

    typedef enum logic {IDLE, UPDATE} scroll_state_t;

    scroll_state_t state, next_state;

    logic [6:0] scroll_x;
    logic       dir_q;
    logic [3:0] step_q;
    logic       latch_params;
    logic       apply_update;

    logic [6:0] tex_u;
    logic [6:0] tex_v;
    logic       v1;
    logic       v2;

    // Scroll FSM: state register
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Scroll FSM: next state. A frame_start that arrives while in UPDATE is
    // dropped, so each pulse produces at most one update.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (frame_start && scroll_en) next_state = UPDATE;
            UPDATE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Scroll FSM: outputs
    always_comb begin
        latch_params = (state == IDLE) && frame_start && scroll_en;
        apply_update = (state == UPDATE);
    end

    // Direction and step are captured on the cycle that enters UPDATE. The
    // offset then changes in UPDATE only, so it stays constant across the
    // visible part of a frame. The 7-bit arithmetic wraps modulo 128, and a
    // step of zero leaves the offset unchanged.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            scroll_x <= 7'd0;
            dir_q    <= 1'b0;
            step_q   <= 4'd0;
        end else begin
            if (latch_params) begin
                dir_q  <= scroll_dir;
                step_q <= scroll_step;
            end
            if (apply_update) begin
                if (dir_q) begin
                    scroll_x <= scroll_x - {3'b000, step_q};
                end else begin
                    scroll_x <= scroll_x + {3'b000, step_q};
                end
            end
        end
    end

    // Texel coordinates. Truncating to 7 bits applies the modulo-128 wrap.
    assign tex_u = 7'(DrawX >> SCALE_SHIFT) + scroll_x;
    assign tex_v = 7'(DrawY >> SCALE_SHIFT);

    // S1: the address is held during blanking, so the ROM input stays quiet.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rom_addr <= 15'd0;
            v1       <= 1'b0;
        end else begin
            v1 <= pixel_valid;
            if (pixel_valid) begin
                rom_addr <= {1'b0, tex_v, tex_u};
            end
        end
    end

    // S2: matches the one-cycle ROM read latency.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            v2 <= 1'b0;
        end else begin
            v2 <= v1;
        end
    end

    // S3: colour select. Black and bg_on low whenever the pixel is not valid.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            bg_on    <= 1'b0;
            bg_Red   <= 8'd0;
            bg_Green <= 8'd0;
            bg_Blue  <= 8'd0;
        end else begin
            bg_on <= v2;
            if (!v2) begin
                bg_Red   <= 8'd0;
                bg_Green <= 8'd0;
                bg_Blue  <= 8'd0;
            end else if (rom_data) begin
                bg_Red   <= COLOR1[23:16];
                bg_Green <= COLOR1[15:8];
                bg_Blue  <= COLOR1[7:0];
            end else begin
                bg_Red   <= COLOR0[23:16];
                bg_Green <= COLOR0[15:8];
                bg_Blue  <= COLOR0[7:0];
            end
        end
    end

endmodule

// File: tb/tb_background_renderer.sv
// -----------------------------------------------------------------------------
// tb_background_renderer
//
// Purpose:
//   Self-checking bench for background_renderer. A behavioural ROM feeds the
//   DUT. A reference model predicts the following after every clock edge:
//     - the ROM address
//     - the texel bit that reaches the output two edges later
//     - the frame offset
//   Directed steps cover the named corner cases. Randomized runs cover pixel
//   traffic and scroll traffic.
// -----------------------------------------------------------------------------
module tb_background_renderer;

    localparam logic [23:0] C1 = 24'h7F3F1F;
    localparam logic [23:0] C0 = 24'h000000;

    logic        Clk;
    logic        Reset_n;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        pixel_valid;
    logic        frame_start;
    logic        scroll_en;
    logic        scroll_dir;
    logic [3:0]  scroll_step;
    logic        rom_data;
    logic [14:0] rom_addr;
    logic        bg_on;
    logic [7:0]  bg_Red;
    logic [7:0]  bg_Green;
    logic [7:0]  bg_Blue;

    background_renderer #(
        .SCALE_SHIFT (2),
        .COLOR1      (C1),
        .COLOR0      (C0)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .pixel_valid (pixel_valid),
        .frame_start (frame_start),
        .scroll_en   (scroll_en),
        .scroll_dir  (scroll_dir),
        .scroll_step (scroll_step),
        .rom_data    (rom_data),
        .rom_addr    (rom_addr),
        .bg_on       (bg_on),
        .bg_Red      (bg_Red),
        .bg_Green    (bg_Green),
        .bg_Blue     (bg_Blue)
    );

    // Background image and its synchronous read port.
    logic rom [0:32767];

    always @(posedge Clk) rom_data <= rom[rom_addr];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model state.
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 2;
    int          m_sx = 0;
    bit          m_pend = 0;
    bit          m_dir = 0;
    int          m_step = 0;
    logic [14:0] exp_addr = 15'd0;
    logic        exp_on;
    logic [23:0] exp_rgb;
    bit          hist_v [0:4095];
    logic        hist_b [0:4095];

    function automatic logic [14:0] addrOf(input int x, input int y, input int sx);
        int u;
        int v;
        u = ((x / 4) + sx) % 128;
        v = (y / 4) % 128;
        return 15'(v * 128 + u);
    endfunction

    task automatic checkOutput();
        vectors++;
        assert (rom_addr === exp_addr) else begin
            miscompares++;
            $error("[TB] FAIL rom_addr edge=%0d observed=%h expected=%h", cyc, rom_addr, exp_addr);
        end
        vectors++;
        assert (bg_on === exp_on) else begin
            miscompares++;
            $error("[TB] FAIL bg_on edge=%0d observed=%b expected=%b", cyc, bg_on, exp_on);
        end
        vectors++;
        assert ({bg_Red, bg_Green, bg_Blue} === exp_rgb) else begin
            miscompares++;
            $error("[TB] FAIL rgb edge=%0d observed=%h expected=%h", cyc, {bg_Red, bg_Green, bg_Blue}, exp_rgb);
        end
    endtask

    // Drives one cycle of inputs, advances one edge, updates the model, checks.
    task automatic applyStimulus(input logic rst_n, input int x, input int y, input logic valid,
                                 input logic fs, input logic en, input logic dir, input int step);
        Reset_n     = rst_n;
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        pixel_valid = valid;
        frame_start = fs;
        scroll_en   = en;
        scroll_dir  = dir;
        scroll_step = 4'(step);
        @(posedge Clk);
        cyc++;
        if (!rst_n) begin
            exp_addr      = 15'd0;
            m_sx          = 0;
            m_pend        = 0;
            hist_v[cyc-1] = 0;
            hist_v[cyc]   = 0;
            exp_on        = 1'b0;
            exp_rgb       = 24'd0;
        end else begin
            if (valid) exp_addr = addrOf(x, y, m_sx);
            hist_v[cyc] = valid;
            hist_b[cyc] = rom[exp_addr];
            exp_on      = hist_v[cyc-2];
            exp_rgb     = !hist_v[cyc-2] ? 24'd0 : (hist_b[cyc-2] ? C1 : C0);
            // A qualified pulse moves the offset one cycle later.
            // Any pulse seen in that cycle is dropped.
            if (m_pend) begin
                m_sx   = dir_to_sx(m_sx, m_dir, m_step);
                m_pend = 0;
            end else if (fs && en) begin
                m_pend = 1;
                m_dir  = dir;
                m_step = step;
            end
        end
        #1;
        checkOutput();
    endtask

    function automatic int dir_to_sx(input int sx, input bit dir, input int step);
        return dir ? (sx - step + 128) % 128 : (sx + step) % 128;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic scrollPulse(input logic dir, input int step);
        applyStimulus(1, 0, 0, 0, 1, 1, dir, step);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkConst(input string tag, input logic [23:0] observed, input logic [23:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            hist_v[i] = 0;
            hist_b[i] = 1'b0;
        end
        for (int i = 0; i < 32768; i++) rom[i] = 1'($urandom_range(0, 1));

        // Reset state
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkConst("reset_outputs", {8'd0, 1'b0, rom_addr, bg_on}, 24'd0);
        idle(2);

        // Basic mapping: (13,9) -> u=3, v=2
        rom[addrOf(13, 9, 0)] = 1'b1;
        applyStimulus(1, 13, 9, 1, 0, 0, 0, 0);
        checkConst("map_addr", {9'd0, rom_addr}, 24'h000103);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkConst("map_on_early", {23'd0, bg_on}, 24'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkConst("map_rgb", {bg_Red, bg_Green, bg_Blue}, 24'h7F3F1F);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkConst("pulse_width", {23'd0, bg_on}, 24'd0);
        idle(2);

        // Random pixel traffic, fixed offset
        for (int i = 0; i < 200; i++)
            applyStimulus(1, $urandom_range(0, 639), $urandom_range(0, 479),
                          1'($urandom_range(0, 3) != 0), 0, 0, 0, 0);
        idle(3);

        // Forward wrap: 0 -> 126 -> 126+5 = 3, then DrawX=508 -> u=2
        scrollPulse(1, 2);
        scrollPulse(0, 5);
        applyStimulus(1, 508, 0, 1, 0, 0, 0, 0);
        checkConst("wrap_u", {17'd0, rom_addr[6:0]}, 24'd2);

        // Reverse wrap with a second pulse during UPDATE: 3 -> 2 -> 125
        scrollPulse(1, 1);
        applyStimulus(1, 0, 0, 0, 1, 1, 1, 5);
        applyStimulus(1, 0, 0, 0, 1, 1, 1, 5);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
        checkConst("rev_wrap_u", {17'd0, rom_addr[6:0]}, 24'd125);

        // Gating: ten pulses with scroll_en low, then the bottom row
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 0, 0, 1, 0, 0, 7);
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        end
        applyStimulus(1, 0, 479, 1, 0, 0, 0, 0);
        checkConst("gate_u", {17'd0, rom_addr[6:0]}, 24'd125);
        checkConst("bottom_v", {17'd0, rom_addr[13:7]}, 24'd119);
        checkConst("addr_bit14", {23'd0, rom_addr[14]}, 24'd0);

        // Zero step, and pixel coincident with frame_start
        scrollPulse(0, 0);
        applyStimulus(1, 40, 40, 1, 1, 1, 0, 9);
        applyStimulus(1, 40, 40, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 40, 1, 0, 0, 0, 0);
        checkConst("same_cycle_u", {17'd0, rom_addr[6:0]}, 24'd6);
        idle(3);

        // Random mixed traffic
        for (int i = 0; i < 300; i++)
            applyStimulus(1, $urandom_range(0, 639), $urandom_range(0, 479),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 15));

        // Reset mid-line, coincident with frame_start, pixels in flight
        applyStimulus(1, 100, 100, 1, 0, 0, 0, 0);
        applyStimulus(1, 104, 100, 1, 0, 0, 0, 0);
        applyStimulus(0, 108, 100, 1, 1, 1, 0, 3);
        checkConst("mid_reset", {7'd0, bg_Red, bg_on, rom_addr[6:0]}, 24'd0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
        checkConst("post_reset_sx", {17'd0, rom_addr[6:0]}, 24'd0);
        applyStimulus(1, 4, 0, 1, 0, 0, 0, 0);
        checkConst("post_reset_off", {23'd0, bg_on}, 24'd0);
        applyStimulus(1, 8, 0, 1, 0, 0, 0, 0);
        checkConst("post_reset_on", {23'd0, bg_on}, 24'd1);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
